// File: rtl/rsa_modexp_if.sv
// Request/response bundle for the rsa_modexp modular-exponentiation engine.
interface rsa_modexp_if #(
  parameter int W     = 8,
  parameter int EXP_W = 8
) ();
  logic             start;
  logic [W-1:0]     msg;
  logic [EXP_W-1:0] exp_in;
  logic [W-1:0]     modulus;
  logic             busy;
  logic             done;
  logic             err;
  logic [W-1:0]     result;

  modport master (
    output start, msg, exp_in, modulus,
    input  busy, done, err, result
  );

  modport slave (
    input  start, msg, exp_in, modulus,
    output busy, done, err, result
  );
endinterface

// File: rtl/rsa_modexp.sv
// Right-to-left square-and-multiply engine: result = msg^exp_in mod modulus.
// Optional RSA_MODEXP_EARLY_EXIT_EN stops the bit loop once no set exponent bits remain.
module rsa_modexp #(
  parameter int W     = 8,
  parameter int EXP_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  rsa_modexp_if.slave  bus
);

  localparam int MC_W = $clog2(W + 1);
  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] TWO_W  = {{(W-2){1'b0}}, 2'b10};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_SQR, S_DONE} state_t;

  // One interleaved shift-add-reduce step; operands below n keep every step below n.
  function automatic logic [W-1:0] mod_step(input logic [W-1:0] r, input logic a_bit,
                                            input logic [W-1:0] b, input logic [W-1:0] n);
    logic [W:0] t;
    t = {r, 1'b0};
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    else                t = t;
    if (a_bit) t = t + {1'b0, b};
    else       t = t;
    if (t >= {1'b0, n}) t = t - {1'b0, n};
    else                t = t;
    return t[W-1:0];
  endfunction

  state_t            state_r;
  logic [W-1:0]      mod_r;
  logic [W-1:0]      base_r;
  logic [W-1:0]      acc_r;
  logic [W-1:0]      mul_a_r;
  logic [W-1:0]      r_r;
  logic [W-1:0]      result_r;
  logic [EXP_W-1:0]  ebits_r;
  logic [MC_W-1:0]   mcnt_r;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
`ifndef RSA_MODEXP_EARLY_EXIT_EN
  localparam int BC_W = $clog2(EXP_W + 1);
  logic [BC_W-1:0]   bitcnt_r;
`endif

  logic [W-1:0] r_next_s;
  logic         mul_last_s;
  logic         sqr_after_mul_s;
  logic         more_bits_s;

  // Multiplier step and loop-continuation decisions
  always_comb begin
    r_next_s   = mod_step(r_r, mul_a_r[W-1], base_r, mod_r);
    mul_last_s = (mcnt_r == MC_W'(W - 1));
`ifdef RSA_MODEXP_EARLY_EXIT_EN
    sqr_after_mul_s = |ebits_r[EXP_W-1:1];
    more_bits_s     = |ebits_r[EXP_W-1:1];
`else
    sqr_after_mul_s = 1'b1;
    more_bits_s     = (bitcnt_r != BC_W'(EXP_W - 1));
`endif
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      mod_r    <= ZERO_W;
      base_r   <= ZERO_W;
      acc_r    <= ZERO_W;
      mul_a_r  <= ZERO_W;
      r_r      <= ZERO_W;
      result_r <= ZERO_W;
      ebits_r  <= {EXP_W{1'b0}};
      mcnt_r   <= {MC_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
`ifndef RSA_MODEXP_EARLY_EXIT_EN
      bitcnt_r <= {BC_W{1'b0}};
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            mod_r   <= bus.modulus;
            base_r  <= bus.msg;
            ebits_r <= bus.exp_in;
            err_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= S_LOAD;
          end
        end
        S_LOAD: begin
          acc_r  <= ONE_W;
          r_r    <= ZERO_W;
          mcnt_r <= {MC_W{1'b0}};
`ifndef RSA_MODEXP_EARLY_EXIT_EN
          bitcnt_r <= {BC_W{1'b0}};
`endif
          if ((mod_r < TWO_W) || (base_r >= mod_r)) begin
            err_r    <= 1'b1;
            result_r <= ZERO_W;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= S_DONE;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
          end else if (ebits_r == {EXP_W{1'b0}}) begin
            result_r <= ONE_W;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= S_DONE;
`endif
          end else if (ebits_r[0]) begin
            mul_a_r <= ONE_W;
            state_r <= S_MUL;
          end else begin
            mul_a_r <= base_r;
            state_r <= S_SQR;
          end
        end
        S_MUL: begin
          mul_a_r <= {mul_a_r[W-2:0], 1'b0};
          r_r     <= r_next_s;
          mcnt_r  <= mcnt_r + MC_W'(1);
          if (mul_last_s) begin
            acc_r  <= r_next_s;
            r_r    <= ZERO_W;
            mcnt_r <= {MC_W{1'b0}};
            if (sqr_after_mul_s) begin
              mul_a_r <= base_r;
              state_r <= S_SQR;
            end else begin
              result_r <= r_next_s;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              state_r  <= S_DONE;
            end
          end
        end
        S_SQR: begin
          mul_a_r <= {mul_a_r[W-2:0], 1'b0};
          r_r     <= r_next_s;
          mcnt_r  <= mcnt_r + MC_W'(1);
          if (mul_last_s) begin
            base_r  <= r_next_s;
            ebits_r <= ebits_r >> 1;
            r_r     <= ZERO_W;
            mcnt_r  <= {MC_W{1'b0}};
`ifndef RSA_MODEXP_EARLY_EXIT_EN
            bitcnt_r <= bitcnt_r + BC_W'(1);
`endif
            // ebits_r[1] is the next bit to consume after this shift
            if (!more_bits_s) begin
              result_r <= acc_r;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              state_r  <= S_DONE;
            end else if (ebits_r[1]) begin
              mul_a_r <= acc_r;
              state_r <= S_MUL;
            end else begin
              mul_a_r <= r_next_s;
              state_r <= S_SQR;
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.err    = err_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_rsa_modexp.sv
// Scoreboard bench for rsa_modexp: directed RSA vectors, error operands, ignored start, mid-run reset.
module tb_rsa_modexp;
  localparam int W     = 8;
  localparam int EXP_W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           c0;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_bad;
  int   done_seen;
  bit   op_active;
  bit   busy_gap;
  exp_t sb[$];

  rsa_modexp_if #(.W(W), .EXP_W(EXP_W)) bus ();

  rsa_modexp #(.W(W), .EXP_W(EXP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] m, input logic [W-1:0] x,
                                     input logic [EXP_W-1:0] e);
    int msb;
    if (m < 8'd2 || x >= m) return 2;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
    if (e == 8'd0) return 2;
    msb = 0;
    for (int i = 0; i < EXP_W; i++) if (e[i]) msb = i;
    return 2 + W * ($countones(e) + msb);
`else
    msb = 0;
    return 2 + W * (EXP_W + $countones(e) + msb);
`endif
  endfunction

  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] x, input logic [EXP_W-1:0] e,
                       input logic [W-1:0] res, input logic er);
    exp_t t;
    @(negedge clk);
    bus.modulus = m;
    bus.msg     = x;
    bus.exp_in  = e;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t.res = res;
    t.err = er;
    t.lat = exp_latency(m, x, e);
    t.c0  = cyc;
    sb.push_back(t);
    busy_gap  = 1'b0;
    op_active = 1'b1;
  endtask

  task automatic wait_done();
    int seen;
    seen = done_seen;
    for (int i = 0; i < 2000 && done_seen == seen; i++) @(negedge clk);
    if (done_seen == seen) begin
      check("done_timeout", 32'd0, 32'd1);
      sb.delete();
      op_active = 1'b0;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals done
  always @(negedge clk) begin
    if (!reset) begin
      if (op_active && !bus.done && !bus.busy) busy_gap = 1'b1;
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result",   32'(bus.result), 32'(e.res));
          check("err",      32'(bus.err), 32'(e.err));
          check("latency",  32'(cyc - e.c0 + 1), 32'(e.lat));
          check("busy_held", 32'(busy_gap), 32'd0);
          check("busy_low_at_done", 32'(bus.busy), 32'd0);
        end
        op_active = 1'b0;
        done_seen++;
      end
    end
  end

  initial begin
    cyc = 0; n_vec = 0; n_bad = 0; done_seen = 0;
    op_active = 1'b0; busy_gap = 1'b0;
    reset = 1'b1;
    bus.start = 1'b0; bus.msg = 8'd0; bus.exp_in = 8'd0; bus.modulus = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    check("rst_err",    32'(bus.err), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    reset = 1'b0;

    issue(8'd15,  8'd7,   8'd3,   8'd13, 1'b0); wait_done();
    issue(8'd15,  8'd13,  8'd3,   8'd7,  1'b0); wait_done();
    issue(8'd143, 8'd9,   8'd7,   8'd48, 1'b0); wait_done();
    issue(8'd143, 8'd48,  8'd103, 8'd9,  1'b0); wait_done();
    issue(8'd15,  8'd15,  8'd3,   8'd0,  1'b1); wait_done();
    issue(8'd1,   8'd0,   8'd3,   8'd0,  1'b1); wait_done();
    issue(8'd143, 8'd100, 8'd0,   8'd1,  1'b0); wait_done();
    issue(8'd143, 8'd0,   8'd5,   8'd0,  1'b0); wait_done();

    // start pulsed mid-run with other operands must be ignored
    issue(8'd143, 8'd9, 8'd7, 8'd48, 1'b0);
    repeat (10) @(negedge clk);
    bus.modulus = 8'd15; bus.msg = 8'd7; bus.exp_in = 8'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // reset mid-operation aborts with no done pulse
    issue(8'd143, 8'd48, 8'd103, 8'd9, 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    op_active = 1'b0;
    @(negedge clk);
    check("abort_busy",   32'(bus.busy), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_done",   32'(bus.done), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_seen), 32'd9);

    issue(8'd15, 8'd7, 8'd3, 8'd13, 1'b0); wait_done();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rsa_modexp.md
Name: rsa_modexp

Overview:
- Sequential modular-exponentiation engine for the 4-bit RSA encoder/decoder datapath; computes result = msg^exp_in mod modulus.
- Sits directly downstream of the key-generation ALU/control logic, which produces N = p*q and the exponents e/d.
- Encryption: control drives exp_in = e. Decryption: control drives exp_in = d.
- Uses right-to-left square-and-multiply; each modular multiply is an interleaved shift-add-reduce taking W cycles.

Parameters:
W, 8, data width of msg, modulus and result (N <= 225 for 4-bit primes)
EXP_W, 8, exponent width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
msg  input  W  plaintext/ciphertext; must be < modulus
exp_in  input  EXP_W  exponent (e or d)
modulus  input  W  N = p*q
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; result/err valid
err  output  1  valid with done; high for illegal operands
result  output  W  exponentiation result; held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset state: IDLE, busy=0, done=0, err=0, result=0, all internal registers 0. Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, LOAD, MUL, SQR, DONE.
- IDLE: start=1 latches msg, exp_in and modulus into internal registers, then goes to LOAD. Inputs are not used again after this edge.
- LOAD (1 cycle): if modulus < 2 or msg >= modulus, go to DONE with err=1 and result=0. Otherwise acc=1, base=msg, ebits=exp, bitcnt=0.
- Bit loop: each exponent bit is consumed LSB first.
  - If ebits[0]=1, MUL (acc = acc*base mod N, W cycles), then SQR.
  - If ebits[0]=0, go straight to SQR.
  - SQR: base = base*base mod N, W cycles. Then ebits >>= 1 and bitcnt++.
  - After EXP_W bits, go to DONE.
- Modular multiply a*b mod N:
  - r=0; for each bit of a from MSB to LSB: r = 2r; if r >= N, r -= N; if bit set, r += b; if r >= N, r -= N.
  - One iteration per cycle. Intermediate values are W+1 bits wide.
  - Operands are always < N, so r < N holds after every step.
- DONE (1 cycle): done=1, result=acc (or 0 on err), busy=0; then IDLE.
- Latency, counted as edges from the start-sampling edge to the cycle in which done=1:
  - Normal: 2 + W*(EXP_W + popcount(exp_in)).
  - Error: 2.
- busy=1 in LOAD, MUL and SQR; 0 in IDLE and DONE.
- start while busy or in DONE: ignored, with no effect on the running operation.
- exp_in=0: result=1, err=0.
- msg=0 with modulus >= 2: result=0, or 1 if exp_in=0.
- err is cleared on the next accepted start.

Optional Feature:
RSA_MODEXP_EARLY_EXIT_EN:
- Defined: after each bit the loop ends as soon as the remaining ebits (after the shift) is 0, and the SQR step is skipped when ebits[7:1]=0.
  - Latency: 2 + W*(popcount(e) + msb_index(e)).
  - exp_in=0 gives latency 2 with result=1.
- Undefined: fixed EXP_W-bit loop with the latency given above.
- result is identical in both builds.

Test Plan:
- modulus=15, msg=7, exp_in=3 -> done with result=13, err=0; then msg=13, exp_in=3 -> result=7. Each latency 82 cycles without the macro, 26 with it.
- modulus=143, msg=9, exp_in=7 -> result=48; then msg=48, exp_in=103 -> result=9. busy stays high throughout and done is a single-cycle pulse.
- modulus=15, msg=15 -> err=1, result=0 after 2 cycles. modulus=1, msg=0 -> err=1.
- exp_in=0, modulus=143, msg=100 -> result=1. msg=0, exp_in=5 -> result=0.
- Pulse start again mid-operation with different operands -> ignored; the first operation's result is returned.
- Assert reset at cycle 20 of an operation -> no done pulse, busy=0 and result=0 on the next cycle; a fresh start then completes correctly.
